// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the 16-bit CPU fetch path.
//   - default RAM word-address width and machine word width
//   - instruction word-0 field positions (opcode / register number) and
//     helpers that slice them
//   - opcode constants
//   - fetch FSM state encodings
package fetch_stage_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int WORD_W     = 16;

  // Word 0 layout: opcode in the high byte, register number in the low byte.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 8;
  localparam int REG_MSB = 7;
  localparam int REG_LSB = 0;

  typedef enum logic [7:0] {
    OP_JMP      = 8'h01,
    OP_JZ       = 8'h02,
    OP_CALL     = 8'h03,
    OP_RET      = 8'h04,
    OP_LOADI    = 8'h05,
    OP_REG2RAM  = 8'h06,
    OP_RAM2REG  = 8'h07,
    OP_ADD      = 8'h08,
    OP_SUB      = 8'h09,
    OP_LOOPEQ   = 8'h0A
  } opcode_t;

  typedef enum logic [1:0] {
    ST_REQ0 = 2'd0,  // port idle, or issuing word 0
    ST_REQ1 = 2'd1,  // capture word 0, issue word 1
    ST_PUSH = 2'd2   // capture word 1, push entry
  } fetch_state_t;

  function automatic logic [7:0] word_op(input logic [WORD_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [7:0] word_regnum(input logic [WORD_W-1:0] w);
    return w[REG_MSB:REG_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO holding decoded instructions.
// Ports:
//   clka, rst        clock, asynchronous active-high reset
//   flush            empty the FIFO at the next edge (wins over push/pop)
//   push, push_data  write one entry; accepted when not full or when a pop
//                    happens in the same cycle
//   pop              drop the head entry (ignored when empty)
//   head_data        current head entry
//   empty, count     occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int WIDTH = 42,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared too so the head fields read as zero out of reset.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 16-bit CPU.
// Owns RAM port B, fetches two-word instructions into a small FIFO, shares
// the port with execute-stage data loads, and handles jump redirects.
// Ports:
//   clka, rst                      clock, asynchronous active-high reset
//   mem_en, mem_addr, mem_rdata    RAM port B (read data one cycle after edge)
//   out_valid, out_ready           instruction handshake to execute
//   out_op, out_regnum, out_imm,
//   out_pc                         head instruction fields, pc of word 0
//   redirect, redirect_pc          jump: flush and refetch from redirect_pc
//   dreq_valid, dreq_addr,
//   dreq_ready                     data-load request, accepted when port free
//   dresp_valid, dresp_data        data-load result, one cycle after accept
module fetch_stage #(
  parameter int ADDR_W     = fetch_stage_pkg::ADDR_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clka,
  input  logic              rst,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_op,
  output logic [7:0]        out_regnum,
  output logic [15:0]       out_imm,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  output logic              dreq_ready,
  output logic              dresp_valid,
  output logic [15:0]       dresp_data
);

  import fetch_stage_pkg::*;

  localparam int ENTRY_W = 8 + 8 + WORD_W + ADDR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] word0_q, word0_d;
  logic              dresp_valid_q, dresp_valid_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] push_data;
  logic               push, pop, in_push;
  logic [CNT_W:0]     cnt_next;
  logic               start_ok;

  assign pop       = out_valid && out_ready;
  assign in_push   = (state_q == ST_PUSH);
  assign push      = in_push && !redirect;
  assign push_data = {word_op(word0_q), word_regnum(word0_q), mem_rdata, fetch_pc_q};

  // Occupancy after this cycle's push/pop; a new instruction may only be
  // started when it is guaranteed a slot.
  assign cnt_next = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_push}
                  - {{CNT_W{1'b0}}, pop};
  assign start_ok = (cnt_next < (CNT_W + 1)'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    word0_d       = word0_q;
    mem_en        = 1'b0;
    mem_addr      = fetch_pc_q;
    dreq_ready    = 1'b0;
    case (state_q)
      ST_REQ0: begin
        // A pending load takes the port ahead of a new fetch.
        if (dreq_valid) begin
          dreq_ready = 1'b1;
          mem_en     = 1'b1;
          mem_addr   = dreq_addr;
        end else if (start_ok) begin
          mem_en  = 1'b1;
          state_d = ST_REQ1;
        end
      end
      ST_REQ1: begin
        word0_d  = mem_rdata;
        mem_en   = 1'b1;
        mem_addr = fetch_pc_q + ADDR_W'(1);
        state_d  = ST_PUSH;
      end
      ST_PUSH: begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(2);
        if (start_ok) begin
          // Look-ahead: issue the next word 0 while pushing this entry.
          mem_en   = 1'b1;
          mem_addr = fetch_pc_q + ADDR_W'(2);
          state_d  = ST_REQ1;
        end else begin
          state_d = ST_REQ0;
          if (dreq_valid) begin
            dreq_ready = 1'b1;
            mem_en     = 1'b1;
            mem_addr   = dreq_addr;
          end
        end
      end
      default: state_d = ST_REQ0;
    endcase
    // Redirect overrides everything; any read issued now would be stale.
    if (redirect) begin
      dreq_ready = 1'b0;
      mem_en     = 1'b0;
      state_d    = ST_REQ0;
      fetch_pc_d = redirect_pc;
    end
    dresp_valid_d = dreq_ready;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q       <= ST_REQ0;
      fetch_pc_q    <= '0;
      word0_q       <= '0;
      dresp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      word0_q       <= word0_d;
      dresp_valid_q <= dresp_valid_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka      (clka),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign {out_op, out_regnum, out_imm, out_pc} = fifo_head;
  assign dresp_valid = dresp_valid_q;
  assign dresp_data  = mem_rdata;

endmodule
